// File: rtl/matmul_tile_scheduler_if.sv
// Operand-request and output-observation bundle of the matmul tile scheduler.
// master = scheduler side, slave = compute core side.
interface matmul_tile_scheduler_if #(
    parameter int ROW_TILES   = 2,
    parameter int COL_TILES   = 2,
    parameter int DEPTH_TILES = 3
);
    localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
    localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
    localparam int DW = (DEPTH_TILES > 1) ? $clog2(DEPTH_TILES) : 1;

    logic          req_valid;
    logic          req_ready;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic [DW-1:0] req_depth;
    logic          req_last;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport master (
        output req_valid, req_row, req_col, req_depth, req_last,
        output out_row, out_col,
        input  req_ready, out_valid, out_ready
    );

    modport slave (
        input  req_valid, req_row, req_col, req_depth, req_last,
        input  out_row, out_col,
        output req_ready, out_valid, out_ready
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks (row, col, depth) operand-tile requests for one matrix multiply and
// tracks core output tiles; optional abort input under MATMUL_SCHED_ABORT_EN.
module matmul_tile_scheduler #(
    parameter int ROW_TILES       = 2,
    parameter int COL_TILES       = 2,
    parameter int DEPTH_TILES     = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef MATMUL_SCHED_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    output logic done,
    matmul_tile_scheduler_if.master bus
);
    localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
    localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
    localparam int DW = (DEPTH_TILES > 1) ? $clog2(DEPTH_TILES) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [RW-1:0] R_MAX  = RW'(ROW_TILES - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(COL_TILES - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(DEPTH_TILES - 1);
    localparam logic [OW-1:0] OS_LIM = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row, row_nxt, orow, orow_nxt;
    logic [CW-1:0] col, col_nxt, ocol, ocol_nxt;
    logic [DW-1:0] depth, depth_nxt;
    logic [OW-1:0] outstanding, os_nxt;
    logic          req_valid_q, req_valid_nxt;
    logic          active, req_hs, out_hs;
    logic          last_req, last_out, abort_hit;

    assign active   = (state == ISSUE) || (state == DRAIN);
    assign req_hs   = req_valid_q & bus.req_ready;
    assign out_hs   = active & bus.out_valid & bus.out_ready;
    assign last_req = req_hs && row == R_MAX && col == C_MAX
                      && depth == D_MAX;
    assign last_out = out_hs && orow == R_MAX && ocol == C_MAX;

`ifdef MATMUL_SCHED_ABORT_EN
    assign abort_hit = abort & active;
`else
    assign abort_hit = 1'b0;
`endif

    assign bus.req_valid = req_valid_q;
    assign bus.req_row   = row;
    assign bus.req_col   = col;
    assign bus.req_depth = depth;
    assign bus.req_last  = (depth == D_MAX);
    assign bus.out_row   = orow;
    assign bus.out_col   = ocol;

    // Next-state, coordinate, outstanding-count and request-valid logic.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        depth_nxt = depth;
        orow_nxt  = orow;
        ocol_nxt  = ocol;
        os_nxt    = outstanding;

        if (req_hs) begin
            if (depth == D_MAX) begin
                depth_nxt = '0;
                if (col == C_MAX) begin
                    col_nxt = '0;
                    row_nxt = (row == R_MAX) ? '0 : row + 1'b1;
                end else begin
                    col_nxt = col + 1'b1;
                end
            end else begin
                depth_nxt = depth + 1'b1;
            end
        end

        if (out_hs) begin
            if (ocol == C_MAX) begin
                ocol_nxt = '0;
                orow_nxt = (orow == R_MAX) ? '0 : orow + 1'b1;
            end else begin
                ocol_nxt = ocol + 1'b1;
            end
        end

        // A finished tile issued and one consumed cancel out.
        unique case ({req_hs & bus.req_last, out_hs})
            2'b10: os_nxt = outstanding + 1'b1;
            2'b01: if (outstanding != '0) os_nxt = outstanding - 1'b1;
            default: ;
        endcase

        unique case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (last_req) state_nxt = DRAIN;
            DRAIN:   if (last_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort_hit) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
            depth_nxt = '0;
            orow_nxt  = '0;
            ocol_nxt  = '0;
            os_nxt    = '0;
        end

        req_valid_nxt = (state_nxt == ISSUE) && (os_nxt < OS_LIM);
    end

    // State, counters and all status outputs registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            depth       <= '0;
            orow        <= '0;
            ocol        <= '0;
            outstanding <= '0;
            req_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            depth       <= depth_nxt;
            orow        <= orow_nxt;
            ocol        <= ocol_nxt;
            outstanding <= os_nxt;
            req_valid_q <= req_valid_nxt;
            busy        <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done        <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: table-driven jobs plus hand sequences for
// output back-pressure, same-cycle count update and mid-job reset.
module tb_matmul_tile_scheduler;
    localparam int RT = 2;
    localparam int CT = 2;
    localparam int DT = 3;
    localparam int MO = 2;
    localparam int NREQ = RT * CT * DT;
    localparam int NOUT = RT * CT;

    typedef struct {
        int r;
        int c;
        int d;
        int last;
    } req_t;

    typedef struct {
        int stall_idx;
        int stall_len;
        bit slow;
        bit restart;
        int exp_vcyc;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
`ifdef MATMUL_SCHED_ABORT_EN
    logic abort = 1'b0;
`endif

    matmul_tile_scheduler_if #(
        .ROW_TILES(RT), .COL_TILES(CT), .DEPTH_TILES(DT)
    ) sif ();

    matmul_tile_scheduler #(
        .ROW_TILES(RT), .COL_TILES(CT),
        .DEPTH_TILES(DT), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef MATMUL_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .bus(sif)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nfail = 0;
    int   nreq, nout, ndone, nvcyc;
    int   req_left = 0;
    int   outs_left = 0;
    int   mdl_os = 0;
    bit   exp_done = 0;
    bit   eb;
    int   pend = 0;
    bit   f_inc = 0;
    bit   f_dec = 0;
    bit   hold_out = 0;
    bit   force_out = 0;
    bit   slow = 0;
    bit   phase = 0;
    bit   prev_stall = 0;
    int   held = 0;
    int   eo;
    req_t e;
    req_t exp_req[$];
    int   exp_out[$];
    job_t jobs[4];

    assign sif.out_valid = force_out | ((pend != 0) && !hold_out);
    assign sif.out_ready = slow ? phase : 1'b1;

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int code(int r, int c, int d, int l);
        return r * 1000 + c * 100 + d * 10 + l;
    endfunction

    function automatic int rcode();
        return code(int'(sif.req_row), int'(sif.req_col),
                    int'(sif.req_depth), int'(sif.req_last));
    endfunction

    function automatic int ocode();
        return int'(sif.out_row) * 10 + int'(sif.out_col);
    endfunction

    // Monitor and reference model, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            req_left = 0;
            outs_left = 0;
            mdl_os = 0;
            exp_done = 0;
            prev_stall = 0;
            f_inc = 0;
            f_dec = 0;
        end else begin
            eb = (req_left > 0) || (outs_left > 0);
            chk("busy", int'(busy), int'(eb));
            chk("done", int'(done), int'(exp_done));
            chk("req_valid", int'(sif.req_valid),
                int'(req_left > 0 && mdl_os < MO));
            chk("req_last", int'(sif.req_last),
                int'(sif.req_depth == DT - 1));
            if (prev_stall && sif.req_valid)
                chk("req_hold", rcode(), held);
            exp_done = 0;
            if (sif.req_valid && sif.req_ready) begin
                nreq++;
                if (exp_req.size() == 0) begin
                    chk("req_extra", rcode(), -1);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_order", rcode(), code(e.r, e.c, e.d, e.last));
                end
                if (req_left > 0) req_left--;
                if (sif.req_last) begin
                    mdl_os++;
                    f_inc = 1;
                end
            end
            if (sif.out_valid && sif.out_ready && eb) begin
                nout++;
                if (exp_out.size() == 0) begin
                    chk("out_extra", ocode(), -1);
                end else begin
                    eo = exp_out.pop_front();
                    chk("out_order", ocode(), eo);
                end
                mdl_os--;
                f_dec = 1;
                if (outs_left > 0) begin
                    outs_left--;
                    if (outs_left == 0) exp_done = 1;
                end
            end
            if (sif.req_valid) nvcyc++;
            if (done) ndone++;
            if (start && !busy && !done) begin
                req_left = NREQ;
                outs_left = NOUT;
            end
            prev_stall = sif.req_valid && !sif.req_ready;
            held = rcode();
        end
    end

    // Core stand-in: one output tile per finished depth sweep.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) pend = 0;
        else pend = pend + int'(f_inc) - int'(f_dec);
        f_inc = 0;
        f_dec = 0;
        phase = ~phase;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        nreq = 0;
        nout = 0;
        ndone = 0;
        nvcyc = 0;
        exp_req.delete();
        exp_out.delete();
    endtask

    task automatic launch();
        req_t t;
        for (int r = 0; r < RT; r++)
            for (int c = 0; c < CT; c++) begin
                for (int d = 0; d < DT; d++) begin
                    t.r = r;
                    t.c = c;
                    t.d = d;
                    t.last = (d == DT - 1) ? 1 : 0;
                    exp_req.push_back(t);
                end
                exp_out.push_back(r * 10 + c);
            end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_nreq(int n, int lim);
        for (int k = 0; k < lim && nreq < n; k++) cyc(1);
        if (nreq < n) chk("req_timeout", nreq, n);
    endtask

    task automatic finish_job(int vc);
        for (int k = 0; k < 300 && ndone == 0; k++) cyc(1);
        cyc(3);
        chk("job_reqs", nreq, NREQ);
        chk("job_outs", nout, NOUT);
        chk("job_dones", ndone, 1);
        if (vc > 0) chk("job_valid_cycles", nvcyc, vc);
        chk("job_leftover", exp_req.size() + exp_out.size(), 0);
    endtask

    task automatic run_job(int i);
        int s;
        clr();
        slow = jobs[i].slow;
        launch();
        if (jobs[i].stall_idx >= 0) begin
            s = jobs[i].stall_idx;
            wait_nreq(s, 100);
            @(posedge clk);
            #1 sif.req_ready = 1'b0;
            @(negedge clk);
            #1;
            chk("stall_coord", rcode(),
                code(s / (CT * DT), (s / DT) % CT, s % DT,
                     (s % DT == DT - 1) ? 1 : 0));
            repeat (jobs[i].stall_len) @(posedge clk);
            #1 sif.req_ready = 1'b1;
        end
        if (jobs[i].restart) begin
            wait_nreq(NREQ, 100);
            @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        finish_job(jobs[i].exp_vcyc);
        slow = 1'b0;
    endtask

    initial begin
        jobs[0] = '{-1, 0, 1'b0, 1'b0, 12};
        jobs[1] = '{4, 5, 1'b0, 1'b0, 17};
        jobs[2] = '{-1, 0, 1'b1, 1'b0, 0};
        jobs[3] = '{-1, 0, 1'b0, 1'b1, 12};
        sif.req_ready = 1'b1;

        #2 rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_req_valid", int'(sif.req_valid), 0);
        chk("rst_req_coord", rcode(), 0);
        chk("rst_out_coord", ocode(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cyc(2);
        chk("idle_busy", int'(busy), 0);

        run_job(0);

        // Output handshakes while idle must not move the output label.
        @(posedge clk);
        #1 force_out = 1'b1;
        repeat (2) @(posedge clk);
        #1 force_out = 1'b0;

        for (int i = 1; i < 4; i++) run_job(i);

        // Output back-pressure throttles issue at two tiles in flight.
        clr();
        hold_out = 1'b1;
        launch();
        wait_nreq(6, 100);
        cyc(3);
        chk("throttle_valid", int'(sif.req_valid), 0);
        chk("throttle_nreq", nreq, 6);
        @(posedge clk);
        #1 hold_out = 1'b0;
        @(posedge clk);
        #1 hold_out = 1'b1;
        @(negedge clk);
        #1;
        chk("resume_valid", int'(sif.req_valid), 1);
        @(posedge clk);
        #1 hold_out = 1'b0;
        finish_job(0);

        // Tile finished and tile consumed in the same cycle.
        clr();
        hold_out = 1'b1;
        launch();
        wait_nreq(5, 100);
        @(posedge clk);
        #1 hold_out = 1'b0;
        @(posedge clk);
        #1 hold_out = 1'b1;
        wait_nreq(9, 100);
        cyc(4);
        chk("same_cycle_nreq", nreq, 9);
        chk("same_cycle_valid", int'(sif.req_valid), 0);
        @(posedge clk);
        #1 hold_out = 1'b0;
        finish_job(0);

        // Reset in the middle of a job, start held during reset.
        clr();
        launch();
        wait_nreq(7, 100);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("rst_at_coord", rcode(), code(1, 0, 1, 0));
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_req_valid", int'(sif.req_valid), 0);
        chk("midrst_req_coord", rcode(), 0);
        chk("midrst_out_coord", ocode(), 0);
        start = 1'b1;
        cyc(2);
        chk("midrst_no_done", ndone, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(3);
        chk("post_rst_idle", int'(busy), 0);
        run_job(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/matmul_tile_scheduler.md
MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL have parameter ROW_TILES, default 2: number of IN1_PARALLELISM-row tiles of operand 1.
REQ-002 SHALL have parameter COL_TILES, default 2: number of IN2_PARALLELISM-column tiles of operand 2.
REQ-003 SHALL have parameter DEPTH_TILES, default 3: number of IN_SIZE-wide tiles along the shared dimension, matching the core IN_DEPTH.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of output tiles issued but not yet consumed.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: launches one full matrix multiply.
REQ-008 SHALL have port busy, output, 1: high from job acceptance until done.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports req_valid (output, 1) and req_ready (input, 1): joint operand-tile request handshake.
REQ-011 SHALL have ports req_row (output, clog2(ROW_TILES)), req_col (output, clog2(COL_TILES)) and req_depth (output, clog2(DEPTH_TILES)): tile coordinates of the current request.
REQ-012 SHALL have port req_last, output, 1: high when req_depth equals DEPTH_TILES-1.
REQ-013 SHALL have ports out_valid (input, 1) and out_ready (input, 1): observed core output handshake.
REQ-014 SHALL have ports out_row (output, row width) and out_col (output, col width): coordinate of the output tile currently presented by the core.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-016 SHALL transition IDLE->ISSUE when start=1; start in any other state SHALL be ignored.
REQ-017 SHALL drive req_valid=1 in ISSUE only while outstanding < MAX_OUTSTANDING, using the registered count.
REQ-018 SHALL hold req_* stable while req_valid=1 and req_ready=0.
REQ-019 SHALL advance coordinates on each req handshake, depth fastest, then col, then row, each wrapping to 0.
REQ-020 SHALL increment outstanding on a handshake with req_last=1, decrement it on out_valid&out_ready, and leave it unchanged when both occur in the same cycle.
REQ-021 SHALL go ISSUE->DRAIN on the handshake of request (ROW_TILES-1, COL_TILES-1, DEPTH_TILES-1).
REQ-022 SHALL advance out_col then out_row, with wrap, on each out_valid&out_ready.
REQ-023 SHALL ignore out handshakes in IDLE and DONE.
REQ-024 SHALL go DRAIN->DONE on the cycle after the ROW_TILES*COL_TILES-th output handshake.
REQ-025 SHALL stay in DONE for exactly one cycle with done=1, then return to IDLE.
REQ-026 SHALL assert busy in ISSUE and DRAIN, and deassert it in IDLE and DONE.
REQ-027 SHALL take, for an unstalled job, exactly ROW_TILES*COL_TILES*DEPTH_TILES ISSUE cycles.
REQ-028 SHALL start ISSUE one cycle after start is sampled in IDLE.

Reset
REQ-029 SHALL, while rst=0, force state=IDLE, every counter and coordinate to 0, and busy=done=req_valid=0.
REQ-030 SHALL abandon the current job without emitting done when rst is asserted mid-job.
REQ-031 SHALL leave IDLE only on a start sampled after rst deasserts.

Configuration
REQ-032 SHALL, when MATMUL_SCHED_ABORT_EN is defined, add an input port abort (1 bit).
REQ-033 SHALL, when abort=1 in ISSUE or DRAIN, return to IDLE the next cycle, zero all counters and pulse no done.
REQ-034 SHALL, when MATMUL_SCHED_ABORT_EN is not defined, omit the abort port and the abort behaviour, all else unchanged.

Verification (ROW_TILES=2, COL_TILES=2, DEPTH_TILES=3, MAX_OUTSTANDING=2)
REQ-035 SHALL cover: start pulse with req_ready=1 and outputs consumed promptly -> 12 requests in order (0,0,0),(0,0,1),(0,0,2),(0,1,0)...(1,1,2); req_last on every third; 4 outputs labelled (0,0),(0,1),(1,0),(1,1); one done pulse.
REQ-036 SHALL cover: out_valid held 0 -> req_valid drops after the 6th request (outstanding=2); one output handshake -> issue resumes the following cycle.
REQ-037 SHALL cover: req_ready=0 for 5 cycles on request (0,1,1) -> req_* held constant; no coordinate advance.
REQ-038 SHALL cover: req handshake with req_last=1 and an out handshake in the same cycle at outstanding=1 -> outstanding stays 1.
REQ-039 SHALL cover: start pulsed again during DRAIN -> ignored; exactly one done pulse.
REQ-040 SHALL cover: rst=0 asserted at request (1,0,1) -> all outputs reset immediately; no done; a fresh start replays from (0,0,0).
